// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    RESP   = 3'd4
  } state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// CPU request/response and memory-controller signals of the cache.
interface set_assoc_cache_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // master: CPU + memory environment; slave: the cache itself
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_way.sv
// One cache way: tag/data/valid per set, combinational read, synchronous write.
import cache_pkg::*;

module cache_way #(
  parameter int TAG_W  = 12,
  parameter int DATA_W = 8,
  parameter int SETS   = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              vld_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              we_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] data_i
);
  logic [SETS-1:0]   vld_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  assign vld_o  = vld_q[idx_i];
  assign tag_o  = tag_q[idx_i];
  assign data_o = data_q[idx_i];

  always_ff @(posedge clk or posedge reset)
    if (reset)     vld_q        <= '0;
    else if (we_i) vld_q[idx_i] <= 1'b1;

  // Tag/data storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk)
    if (we_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= data_i;
    end
endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative cache, one-word lines, per-set FIFO victim, write-through no-allocate.
import cache_pkg::*;

module set_assoc_cache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int WAYS   = 2,
  parameter int SETS   = 16
) (
  input  logic             clk,
  input  logic             reset,
  set_assoc_cache_if.slave bus
);
  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? clog2(WAYS) : 1;

  state_e            state_q;
  logic              wr_q, hit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_req_q, mem_we_q, resp_valid_q, resp_hit_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, resp_rdata_q;
  logic [WAY_W-1:0]  fifo_q [SETS];

  logic [IDX_W-1:0]             idx;
  logic [TAG_W-1:0]             tag;
  logic [DATA_W-1:0]            wr_data, hit_data;
  logic                         hit, fill;
  logic [WAYS-1:0]              way_vld, way_hit, way_we;
  logic [WAYS-1:0][TAG_W-1:0]   way_tag;
  logic [WAYS-1:0][DATA_W-1:0]  way_data;

  assign idx     = addr_q[IDX_W-1:0];
  assign tag     = addr_q[ADDR_W-1:IDX_W];
  assign fill    = (state_q == MEM_RD) && bus.mem_ack;
  assign wr_data = (state_q == LOOKUP) ? wdata_q : bus.mem_rdata;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(.TAG_W(TAG_W), .DATA_W(DATA_W), .SETS(SETS), .IDX_W(IDX_W)) u_way (
      .clk(clk), .reset(reset), .idx_i(idx),
      .vld_o(way_vld[w]), .tag_o(way_tag[w]), .data_o(way_data[w]),
      .we_i(way_we[w]), .tag_i(tag), .data_i(wr_data)
    );
    assign way_hit[w] = way_vld[w] && (way_tag[w] == tag);
    // Write hits update in place; read fills go to the set's FIFO victim.
    assign way_we[w]  = ((state_q == LOOKUP) && wr_q && way_hit[w]) ||
                        (fill && (fifo_q[idx] == WAY_W'(w)));
  end

  always_comb begin
    hit      = |way_hit;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_data = way_data[w];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int s = 0; s < SETS; s++) fifo_q[s] <= '0;
    else if (fill)
      fifo_q[idx] <= (fifo_q[idx] == WAY_W'(WAYS - 1)) ? '0 : fifo_q[idx] + WAY_W'(1);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      hit_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_hit_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE:
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            state_q <= LOOKUP;
          end
        LOOKUP: begin
          hit_q <= hit;
          if (wr_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
            state_q     <= MEM_WR;
          end else if (hit) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= hit_data;
            resp_hit_q   <= 1'b1;
            state_q      <= RESP;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= addr_q;
            state_q    <= MEM_RD;
          end
        end
        MEM_RD:
          if (bus.mem_ack) begin
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= bus.mem_rdata;
            resp_hit_q   <= 1'b0;
            state_q      <= RESP;
          end
        MEM_WR:
          if (bus.mem_ack) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_hit_q   <= hit_q;
            state_q      <= RESP;
          end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule
